// File: rtl/l15_req_port_arbiter.sv
// Arbiter sharing the single L1.5 request channel among the cache-side requesters.
// Fixed priority with starvation promotion, per-port credit limiting, registered output held until ack.

module l15_arb_port #(
  parameter int StarveTh       = 16,
  parameter int MaxOutstanding = 4,
  parameter int WW             = 5,
  parameter int CW             = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic grant,
  input  logic rtrn,
  output logic eligible,
  output logic starved,
  output logic underflow
);
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] cred;

  localparam logic [WW-1:0] WAIT_MAX = WW'(StarveTh);
  localparam logic [CW-1:0] CRED_MAX = CW'(MaxOutstanding);

  assign eligible  = valid & (cred < CRED_MAX);
  assign starved   = eligible & (wait_cnt == WAIT_MAX);
  // A simultaneous grant covers the return, so only an unmatched return at zero is an error.
  assign underflow = rtrn & ~grant & (cred == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!eligible || grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred <= '0;
    end else begin
      case ({grant, rtrn})
        2'b10:   cred <= cred + 1'b1;
        2'b01:   if (cred != '0) cred <= cred - 1'b1;
        default: cred <= cred;
      endcase
    end
  end
endmodule

module l15_req_port_arbiter #(
  parameter int NumPorts       = 6,
  parameter int DataWidth      = 128,
  parameter int StarveTh       = 16,
  parameter int MaxOutstanding = 4,
  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           req_valid_i,
  input  logic [NumPorts*DataWidth-1:0] req_data_i,
  output logic [NumPorts-1:0]           req_ready_o,
  output logic                          l15_val_o,
  output logic [DataWidth-1:0]          l15_data_o,
  output logic [PW-1:0]                 l15_portid_o,
  input  logic                          l15_ack_i,
  input  logic                          rtrn_valid_i,
  input  logic [PW-1:0]                 rtrn_portid_i,
  output logic                          retire_err_o
);
  localparam int WW = $clog2(StarveTh + 1);
  localparam int CW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                               state, state_nxt;
  logic [NumPorts-1:0]                  eligible, starved, underflow, grant, rtrn;
  logic [NumPorts-1:0][DataWidth-1:0]   data_arr;
  logic [PW-1:0]                        win_idx, star_idx;
  logic                                 any_star, take;

  assign data_arr = req_data_i;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign rtrn[p] = rtrn_valid_i & (rtrn_portid_i == PW'(p));
    l15_arb_port #(
      .StarveTh(StarveTh), .MaxOutstanding(MaxOutstanding), .WW(WW), .CW(CW)
    ) u_port (
      .clk      (clk_i),
      .rst      (rst_i),
      .valid    (req_valid_i[p]),
      .grant    (grant[p]),
      .rtrn     (rtrn[p]),
      .eligible (eligible[p]),
      .starved  (starved[p]),
      .underflow(underflow[p])
    );
  end

  // Descending scan leaves the lowest index; a starved port overrides plain priority.
  always_comb begin
    win_idx  = '0;
    star_idx = '0;
    any_star = 1'b0;
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (eligible[p]) win_idx = PW'(p);
      if (starved[p]) begin
        star_idx = PW'(p);
        any_star = 1'b1;
      end
    end
    if (any_star) win_idx = star_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    grant     = '0;
    case (state)
      IDLE: begin
        take = |eligible;
        if (take) state_nxt = HOLD;
      end
      HOLD: begin
        if (l15_ack_i) begin
          take      = |eligible;
          state_nxt = take ? HOLD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) grant[win_idx] = 1'b1;
  end

  assign req_ready_o = grant;
  assign l15_val_o   = (state == HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      l15_data_o   <= '0;
      l15_portid_o <= '0;
    end else if (take) begin
      l15_data_o   <= data_arr[win_idx];
      l15_portid_o <= win_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           retire_err_o <= 1'b0;
    else if (|underflow) retire_err_o <= 1'b1;
  end
endmodule

// File: tb/tb_l15_req_port_arbiter.sv
// Directed bench for l15_req_port_arbiter: vector table plus multi-cycle corner sequences.

module tb_l15_req_port_arbiter;
  localparam int NP = 6;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req_valid = '0;
  logic [NP*DW-1:0]  req_data;
  logic [NP-1:0]     req_ready;
  logic              l15_val;
  logic [DW-1:0]     l15_data;
  logic [2:0]        l15_portid;
  logic              l15_ack = 1'b0;
  logic              rtrn_valid = 1'b0;
  logic [2:0]        rtrn_portid = '0;
  logic              retire_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l15_req_port_arbiter #(.NumPorts(NP), .DataWidth(DW), .StarveTh(16), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .l15_val_o(l15_val), .l15_data_o(l15_data),
    .l15_portid_o(l15_portid), .l15_ack_i(l15_ack), .rtrn_valid_i(rtrn_valid),
    .rtrn_portid_i(rtrn_portid), .retire_err_o(retire_err)
  );

  function automatic logic [DW-1:0] pdata(int p);
    return {4{32'hC0DE_0000 | 32'(p)}};
  endfunction

  for (genvar p = 0; p < NP; p++) begin : g_data
    assign req_data[p*DW +: DW] = pdata(p);
  end

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; l15_ack = 1'b0; rtrn_valid = 1'b0; rtrn_portid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NP-1:0] valid;
    logic          ack;
    logic          rv;
    logic [2:0]    rid;
    logic [NP-1:0] exp_ready;
    logic          exp_val;
    logic [2:0]    exp_pid;
    logic          exp_err;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [NP-1:0] v, logic a, logic rv, logic [2:0] rid,
                              logic [NP-1:0] er, logic ev, logic [2:0] ep, logic ee);
    vec_t t;
    t.valid = v; t.ack = a; t.rv = rv; t.rid = rid;
    t.exp_ready = er; t.exp_val = ev; t.exp_pid = ep; t.exp_err = ee;
    return t;
  endfunction

  initial begin
    int out0;
    // Ports 1 and 4 together, back-to-back handoff, then credit-return error.
    vecs[0]  = mk(6'b000000, 0, 0, 0, 6'b000000, 0, 0, 0);
    vecs[1]  = mk(6'b010010, 0, 0, 0, 6'b000010, 0, 0, 0);
    vecs[2]  = mk(6'b010000, 0, 0, 0, 6'b000000, 1, 1, 0);
    vecs[3]  = mk(6'b010000, 1, 0, 0, 6'b010000, 1, 1, 0);
    vecs[4]  = mk(6'b000000, 0, 0, 0, 6'b000000, 1, 4, 0);
    vecs[5]  = mk(6'b000000, 1, 0, 0, 6'b000000, 1, 4, 0);
    vecs[6]  = mk(6'b000000, 0, 0, 0, 6'b000000, 0, 4, 0);
    vecs[7]  = mk(6'b000000, 0, 1, 3, 6'b000000, 0, 4, 0);
    vecs[8]  = mk(6'b000000, 0, 0, 0, 6'b000000, 0, 4, 1);
    vecs[9]  = mk(6'b000000, 0, 1, 4, 6'b000000, 0, 4, 1);
    vecs[10] = mk(6'b000000, 0, 1, 1, 6'b000000, 0, 4, 1);

    do_reset();
    chk("reset_data", l15_data, '0);
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid; l15_ack = vecs[i].ack;
      rtrn_valid = vecs[i].rv; rtrn_portid = vecs[i].rid;
      #1;
      chk($sformatf("v%0d_ready", i), DW'(req_ready), DW'(vecs[i].exp_ready));
      chk($sformatf("v%0d_val", i), DW'(l15_val), DW'(vecs[i].exp_val));
      chk($sformatf("v%0d_pid", i), DW'(l15_portid), DW'(vecs[i].exp_pid));
      chk($sformatf("v%0d_err", i), DW'(retire_err), DW'(vecs[i].exp_err));
      if (vecs[i].exp_val) chk($sformatf("v%0d_data", i), l15_data, pdata(vecs[i].exp_pid));
      @(negedge clk);
    end

    // Starvation: port 0 always valid, port 5 promoted on its 17th waiting cycle.
    do_reset();
    out0 = 0;
    for (int c = 1; c <= 18; c++) begin
      req_valid = 6'b100001; l15_ack = l15_val;
      rtrn_valid = (out0 > 0); rtrn_portid = 3'd0;
      #1;
      chk($sformatf("starve_c%0d", c), DW'(req_ready), DW'((c == 17) ? 6'b100000 : 6'b000001));
      out0 = out0 + int'(req_ready[0]) - int'(rtrn_valid);
      @(negedge clk);
    end
    chk("starve_err", DW'(retire_err), DW'(1'b0));

    // Hold without ack, then async reset while holding.
    do_reset();
    req_valid = 6'b000100; l15_ack = 1'b0; rtrn_valid = 1'b0;
    #1 chk("hold_first", DW'(req_ready), DW'(6'b000100));
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      req_valid = 6'b001100; l15_ack = 1'b0;
      #1;
      chk($sformatf("hold_ready%0d", c), DW'(req_ready), DW'(6'b000000));
      chk($sformatf("hold_pid%0d", c), DW'(l15_portid), DW'(2));
      chk($sformatf("hold_data%0d", c), l15_data, pdata(2));
      @(negedge clk);
    end
    req_valid = 6'b000100; l15_ack = 1'b1;
    #1 chk("hold_ack_ready", DW'(req_ready), DW'(6'b000100));
    @(negedge clk);
    req_valid = '0; l15_ack = 1'b0;
    #1 chk("pre_rst_val", DW'(l15_val), DW'(1'b1));
    rst = 1'b1;
    #1 chk("async_rst_val", DW'(l15_val), DW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_val", DW'(l15_val), DW'(1'b0));
    @(negedge clk);

    // Credits: port 2 granted four times (reset cleared its earlier two), then blocked.
    for (int c = 0; c < 4; c++) begin
      req_valid = 6'b000100; l15_ack = l15_val; rtrn_valid = 1'b0;
      #1 chk($sformatf("cred_grant%0d", c), DW'(req_ready), DW'(6'b000100));
      @(negedge clk);
    end
    req_valid = 6'b001100; l15_ack = l15_val;
    #1 chk("cred_full_p3", DW'(req_ready), DW'(6'b001000));
    @(negedge clk);
    req_valid = 6'b000100; l15_ack = l15_val; rtrn_valid = 1'b1; rtrn_portid = 3'd2;
    #1;
    chk("cred_blocked", DW'(req_ready), DW'(6'b000000));
    chk("cred_pid3", DW'(l15_portid), DW'(3));
    @(negedge clk);
    req_valid = 6'b000100; l15_ack = l15_val; rtrn_valid = 1'b0;
    #1;
    chk("cred_idle", DW'(l15_val), DW'(1'b0));
    chk("cred_regain", DW'(req_ready), DW'(6'b000100));
    chk("cred_err", DW'(retire_err), DW'(1'b0));
    @(negedge clk);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
